// File: rtl/fft_pkg.sv
// Shared types and helpers for the FFT output reorder path.
// Holds the complex sample type, the default component width and the
// index bit-reversal helper used to place bit-reversed arrivals.
package fft_pkg;

  localparam int FFT_NB_DEFAULT = 10;
  localparam int CPLX_NB        = FFT_NB_DEFAULT;

  typedef struct packed {
    logic signed [CPLX_NB-1:0] re;
    logic signed [CPLX_NB-1:0] im;
  } cplx_t;

  // Reverse the low nbits of idx; bits above nbits come back as zero.
  function automatic logic [31:0] bitrev(input logic [31:0] idx, input int unsigned nbits);
    logic [31:0] r;
    r = 32'd0;
    for (int unsigned i = 32'd0; i < 32'd32; i++) begin
      if (i < nbits) begin
        r[5'(nbits - 32'd1 - i)] = idx[5'(i)];
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_reorder_bank.sv
// One frame bank of the ping-pong reorder memory: NS complex words with a
// write port, an asynchronous read port and a frame-full flag. Contents
// are not reset; only the full flag is.
module fft_reorder_bank
  import fft_pkg::*;
#(
  parameter int W  = 2 * FFT_NB_DEFAULT,
  parameter int NS = 8,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [W-1:0]  wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [W-1:0]  rd_data,
  input  logic          set_full,
  input  logic          clr_full,
  output logic          full
);

  logic [W-1:0] mem_r [NS];

  // Store one complex word per accepted input; storage needs no reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_r[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_r[rd_addr];

  // Frame-full flag: set when the last word lands, cleared when the reader releases it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full <= 1'b0;
    end else if (set_full) begin
      full <= 1'b1;
    end else if (clr_full) begin
      full <= 1'b0;
    end else begin
      full <= full;
    end
  end

endmodule

// File: rtl/fft_bitrev_reorder.sv
// Bit-reversed to natural-order frame reorder buffer behind the radix-2 FFT.
// Two banks ping-pong: the writer fills one bank at bit-reversed addresses
// while the reader streams the other out in natural order through a
// registered output stage. in_ready depends on registers only.
// Optional build macro FFT_REORDER_FRAME_CHECK_EN adds in_last/frame_err
// framing checks on the input side.
module fft_bitrev_reorder
  import fft_pkg::*;
#(
  parameter int NB      = FFT_NB_DEFAULT,
  parameter int LOG2_NS = 3,
  parameter int NS      = 1 << LOG2_NS
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [NB-1:0]      in_re,
  input  logic [NB-1:0]      in_im,
`ifdef FFT_REORDER_FRAME_CHECK_EN
  input  logic               in_last,
  output logic               frame_err,
`endif
  output logic               out_valid,
  input  logic               out_ready,
  output logic [NB-1:0]      out_re,
  output logic [NB-1:0]      out_im,
  output logic [LOG2_NS-1:0] out_idx,
  output logic               out_last
);

  localparam logic [LOG2_NS-1:0] LAST_IDX = LOG2_NS'(NS - 1);

  logic                 wbank_r;
  logic                 rbank_r;
  logic [LOG2_NS-1:0]   wcnt_r;
  logic [LOG2_NS-1:0]   rcnt_r;

  logic [1:0]           full_s;
  logic [1:0]           wr_en_s;
  logic [1:0]           set_full_s;
  logic [1:0]           clr_full_s;
  logic [2*NB-1:0]      rd_data0_s;
  logic [2*NB-1:0]      rd_data1_s;
  logic [2*NB-1:0]      rd_sel_s;
  logic [LOG2_NS-1:0]   wr_addr_s;
  logic                 in_fire_s;
  logic                 commit_s;
  logic                 discard_s;
  logic                 load_s;
  logic                 release_s;
`ifdef FFT_REORDER_FRAME_CHECK_EN
  logic                 frame_err_s;
`endif

  assign in_ready = !full_s[wbank_r];

  // Write-side decode: transfer, bit-reversed address, frame commit or discard.
  always_comb begin
    in_fire_s = in_valid && !full_s[wbank_r];
    wr_addr_s = LOG2_NS'(bitrev(32'(wcnt_r), 32'(LOG2_NS)));
`ifdef FFT_REORDER_FRAME_CHECK_EN
    discard_s   = in_fire_s && in_last && (wcnt_r != LAST_IDX);
    commit_s    = in_fire_s && (wcnt_r == LAST_IDX);
    frame_err_s = discard_s || (in_fire_s && !in_last && (wcnt_r == LAST_IDX));
`else
    discard_s   = 1'b0;
    commit_s    = in_fire_s && (wcnt_r == LAST_IDX);
`endif
    wr_en_s    = {in_fire_s && wbank_r, in_fire_s && !wbank_r};
    set_full_s = {commit_s && wbank_r, commit_s && !wbank_r};
  end

  // Read-side decode: load the output stage when it is free and a full bank waits.
  always_comb begin
    load_s     = (!out_valid || out_ready) && full_s[rbank_r];
    release_s  = load_s && (rcnt_r == LAST_IDX);
    clr_full_s = {release_s && rbank_r, release_s && !rbank_r};
    rd_sel_s   = rbank_r ? rd_data1_s : rd_data0_s;
  end

  fft_reorder_bank #(.W(2*NB), .NS(NS), .AW(LOG2_NS)) u_bank0 (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en_s[0]),
    .wr_addr  (wr_addr_s),
    .wr_data  ({in_re, in_im}),
    .rd_addr  (rcnt_r),
    .rd_data  (rd_data0_s),
    .set_full (set_full_s[0]),
    .clr_full (clr_full_s[0]),
    .full     (full_s[0])
  );

  fft_reorder_bank #(.W(2*NB), .NS(NS), .AW(LOG2_NS)) u_bank1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en_s[1]),
    .wr_addr  (wr_addr_s),
    .wr_data  ({in_re, in_im}),
    .rd_addr  (rcnt_r),
    .rd_data  (rd_data1_s),
    .set_full (set_full_s[1]),
    .clr_full (clr_full_s[1]),
    .full     (full_s[1])
  );

  // Write counter and write-bank pointer; a discarded partial frame restarts at 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wcnt_r  <= {LOG2_NS{1'b0}};
      wbank_r <= 1'b0;
    end else if (commit_s) begin
      wcnt_r  <= {LOG2_NS{1'b0}};
      wbank_r <= !wbank_r;
    end else if (discard_s) begin
      wcnt_r  <= {LOG2_NS{1'b0}};
      wbank_r <= wbank_r;
    end else if (in_fire_s) begin
      wcnt_r  <= wcnt_r + 1'b1;
      wbank_r <= wbank_r;
    end else begin
      wcnt_r  <= wcnt_r;
      wbank_r <= wbank_r;
    end
  end

  // Read counter and read-bank pointer; the counter wraps naturally after NS-1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rcnt_r  <= {LOG2_NS{1'b0}};
      rbank_r <= 1'b0;
    end else if (load_s) begin
      rcnt_r  <= rcnt_r + 1'b1;
      rbank_r <= release_s ? !rbank_r : rbank_r;
    end else begin
      rcnt_r  <= rcnt_r;
      rbank_r <= rbank_r;
    end
  end

  // Registered output stage; holds every field while stalled by out_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_re    <= {NB{1'b0}};
      out_im    <= {NB{1'b0}};
      out_idx   <= {LOG2_NS{1'b0}};
      out_last  <= 1'b0;
    end else if (load_s) begin
      out_valid <= 1'b1;
      out_re    <= rd_sel_s[2*NB-1:NB];
      out_im    <= rd_sel_s[NB-1:0];
      out_idx   <= rcnt_r;
      out_last  <= (rcnt_r == LAST_IDX);
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end else begin
      out_valid <= out_valid;
    end
  end

`ifdef FFT_REORDER_FRAME_CHECK_EN
  // One-cycle framing error pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_err <= 1'b0;
    end else begin
      frame_err <= frame_err_s;
    end
  end
`endif

endmodule
